// File: rtl/delay_pkg.sv
// Shared types and constants for the multi-channel delay timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package delay_pkg;

    // Per-channel state: IDLE (waiting for a start condition) or RUN (counting).
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    // Values of the per-channel mode input.
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Reset value of every channel period.
    localparam int N_DEFAULT_G = 400000;

endpackage : delay_pkg

// File: rtl/delay_chan.sv
// One timer channel: IDLE/RUN FSM, counter, shadow/active period, sig/err/flg monitors.
// Latency: sig is registered, high the cycle after cnt == active period is observed.
// Backpressure: none; en is level-sensitive and drops the channel to IDLE on the next edge.
//
// Ports: en/mode/arm   start controls (mode latched on entry to RUN, arm used in one-shot only)
//        wr_vld/wr_dat period write into the shadow register
//        sig/busy/err/flg registered outputs; sig_nxt is the next-state sig for the parent's any_sig flop
module delay_chan
    import delay_pkg::*;
#(
    parameter int CBITS     = 19,
    parameter int N_DEFAULT = N_DEFAULT_G
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             arm,
    input  logic             wr_vld,
    input  logic [CBITS-1:0] wr_dat,
    output logic             sig,
    output logic             sig_nxt,
    output logic             busy,
    output logic             err,
    output logic             flg
);

    chan_state_e      state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [CBITS-1:0] act_q, act_d;
    logic [CBITS-1:0] shd_q, shd_d;
    logic             mode_q, mode_d;
    logic             sig_q, sig_d;
    logic             flg_q, flg_d;
    logic             tc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        mode_d  = mode_q;
        sig_d   = 1'b0;
        shd_d   = wr_vld ? wr_dat : shd_q;
        tc      = (cnt_q == act_q);

        case (state_q)
            IDLE: begin
                // While idle the active period tracks the shadow, so a write
                // lands in both on the same edge.
                cnt_d = '0;
                act_d = shd_d;
                if (en && ((mode == MODE_PERIODIC) || arm)) begin
                    state_d = RUN;
                    mode_d  = mode;
                end
            end
            RUN: begin
                if (!en) begin
                    // Disable beats a coincident terminal count: no pulse.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tc) begin
                    // Interval boundary: the only point a running channel
                    // picks up a new period, including one written right now.
                    cnt_d = '0;
                    sig_d = 1'b1;
                    act_d = shd_d;
                    if (mode_q == MODE_ONESHOT) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CBITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Monitor reflects the registered cnt/active pair it is registered with.
        flg_d = (cnt_d <= act_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            act_q   <= CBITS'(N_DEFAULT);
            shd_q   <= CBITS'(N_DEFAULT);
            mode_q  <= MODE_PERIODIC;
            sig_q   <= 1'b0;
            flg_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            mode_q  <= mode_d;
            sig_q   <= sig_d;
            flg_q   <= flg_d;
        end
    end

    assign sig     = sig_q;
    assign sig_nxt = sig_d;
    assign busy    = (state_q == RUN);
    assign flg     = flg_q;
    assign err     = ~flg_q;

endmodule : delay_chan

// File: rtl/multi_delay.sv
// NCH independent programmable delay/period timers with config decode.
// Latency: all outputs registered; cfg_err one cycle after the bad write, any_sig aligned with sig.
// Backpressure: none; config writes are always accepted (out-of-range ones are dropped).
//
// Ports: en/mode/arm        per-channel start controls
//        cfg_we/cfg_ch/cfg_period  period write into the shadow of one channel
//        cfg_err            pulse for a write addressed past the last channel
//        sig/busy/err/flg   per-channel outputs, any_sig = OR of sig
module multi_delay
    import delay_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int CBITS     = 19,
    parameter int N_DEFAULT = N_DEFAULT_G,
    parameter int IBITS     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   mode,
    input  logic [NCH-1:0]   arm,
    input  logic             cfg_we,
    input  logic [IBITS-1:0] cfg_ch,
    input  logic [CBITS-1:0] cfg_period,
    output logic             cfg_err,
    output logic [NCH-1:0]   sig,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   err,
    output logic [NCH-1:0]   flg,
    output logic             any_sig
);

    logic [NCH-1:0] sig_nxt;
    logic           cfg_err_q, cfg_err_d;
    logic           any_sig_q, any_sig_d;

    always_comb begin
        cfg_err_d = cfg_we && (int'(cfg_ch) >= NCH);
        // Built from the channels' next-state sig so it rises with them.
        any_sig_d = |sig_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err_q <= 1'b0;
            any_sig_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
            any_sig_q <= any_sig_d;
        end
    end

    assign cfg_err = cfg_err_q;
    assign any_sig = any_sig_q;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic wr_vld;
        assign wr_vld = cfg_we && (int'(cfg_ch) == i);

        delay_chan #(
            .CBITS     (CBITS),
            .N_DEFAULT (N_DEFAULT)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .mode    (mode[i]),
            .arm     (arm[i]),
            .wr_vld  (wr_vld),
            .wr_dat  (cfg_period),
            .sig     (sig[i]),
            .sig_nxt (sig_nxt[i]),
            .busy    (busy[i]),
            .err     (err[i]),
            .flg     (flg[i])
        );
    end

endmodule : multi_delay

// File: tb/tb_multi_delay.sv
// Scoreboard bench: directed stimulus pushes per-cycle expectations, a negedge monitor checks them.
// Main instance NCH=4/CBITS=4/N_DEFAULT=5; second instance NCH=3 exercises out-of-range config.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_multi_delay;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;

    logic [3:0] en, mode, arm;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [3:0] cfg_period;
    logic       cfg_err, any_sig;
    logic [3:0] sig, busy, err, flg;

    logic [2:0] en2, mode2, arm2;
    logic       cfg_we2;
    logic [1:0] cfg_ch2;
    logic [3:0] cfg_period2;
    logic       cfg_err2, any_sig2;
    logic [2:0] sig2, busy2, err2, flg2;

    multi_delay #(.NCH(4), .CBITS(4), .N_DEFAULT(5)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .arm(arm),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .cfg_err(cfg_err), .sig(sig), .busy(busy), .err(err), .flg(flg),
        .any_sig(any_sig)
    );

    multi_delay #(.NCH(3), .CBITS(4), .N_DEFAULT(5)) dut3 (
        .clk(clk), .rst(rst), .en(en2), .mode(mode2), .arm(arm2),
        .cfg_we(cfg_we2), .cfg_ch(cfg_ch2), .cfg_period(cfg_period2),
        .cfg_err(cfg_err2), .sig(sig2), .busy(busy2), .err(err2), .flg(flg2),
        .any_sig(any_sig2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] sig;
        logic [3:0] busy;
        logic [2:0] sig2;
        logic [2:0] busy2;
        logic       cerr2;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void push_exp(exp_t e);
        int idx = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc > e.cyc) begin
                idx = i;
                break;
            end
        end
        exp_q.insert(idx, e);
    endfunction

    function automatic void ex(int c, logic [3:0] s, logic [3:0] bz);
        exp_t e;
        e.cyc = c; e.sig = s; e.busy = bz; e.sig2 = '0; e.busy2 = '0; e.cerr2 = 1'b0;
        push_exp(e);
    endfunction

    function automatic void ex2(int c, logic [2:0] s, logic [2:0] bz, logic ce);
        exp_t e;
        e.cyc = c; e.sig = '0; e.busy = '0; e.sig2 = s; e.busy2 = bz; e.cerr2 = ce;
        push_exp(e);
    endfunction

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: invariant every cycle, scheduled expectations when due,
    // and any output activity with nothing scheduled is an error.
    always @(negedge clk) begin : mon
        exp_t e;
        n_cmp++;
        if (err !== 4'b0 || flg !== 4'hF || err2 !== 3'b0 || flg2 !== 3'h7) begin
            n_fail++;
            $display("FAIL invariant @%0d: err=%b flg=%b err2=%b flg2=%b, required err=0 flg=all ones",
                     cyc, err, flg, err2, flg2);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL missed @%0d: expectation for cycle %0d never checked", cyc, e.cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (sig !== e.sig || busy !== e.busy || any_sig !== (|e.sig) || cfg_err !== 1'b0 ||
                sig2 !== e.sig2 || busy2 !== e.busy2 || any_sig2 !== (|e.sig2) || cfg_err2 !== e.cerr2) begin
                n_fail++;
                $display("FAIL outputs @%0d: got sig=%b busy=%b any=%b cerr=%b sig2=%b busy2=%b any2=%b cerr2=%b; want sig=%b busy=%b any=%b cerr=0 sig2=%b busy2=%b any2=%b cerr2=%b",
                         cyc, sig, busy, any_sig, cfg_err, sig2, busy2, any_sig2, cfg_err2,
                         e.sig, e.busy, |e.sig, e.sig2, e.busy2, |e.sig2, e.cerr2);
            end
        end else if (sig !== 4'b0 || sig2 !== 3'b0 || any_sig !== 1'b0 || any_sig2 !== 1'b0 ||
                     cfg_err !== 1'b0 || cfg_err2 !== 1'b0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected @%0d: sig=%b any=%b cerr=%b sig2=%b any2=%b cerr2=%b, required all 0",
                     cyc, sig, any_sig, cfg_err, sig2, any_sig2, cfg_err2);
        end
    end

    initial begin : stim
        int b;
        rst = 1'b1;
        en = '0; mode = '0; arm = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        en2 = '0; mode2 = '0; arm2 = '0; cfg_we2 = 1'b0; cfg_ch2 = '0; cfg_period2 = '0;
        ex(1, 4'b0000, 4'b0000);
        ex(2, 4'b0000, 4'b0000);
        #1 rst = 1'b0;
        wait_to(3);
        rst = 1'b1;

        // Periodic ch0 at default P=5: pulse every 6 cycles from the first RUN cycle.
        @(negedge clk); b = cyc;
        ex(b + 1, 4'b0000, 4'b0001);
        ex(b + 7, 4'b0001, 4'b0001);
        ex(b + 13, 4'b0001, 4'b0001);
        ex(b + 19, 4'b0001, 4'b0001);
        ex(b + 21, 4'b0000, 4'b0000);
        en[0] = 1'b1; mode[0] = 1'b0;
        wait_to(b + 20); en[0] = 1'b0;
        wait_to(b + 23);

        // One-shot ch1, P=3: busy 4 cycles, single pulse, re-arm mid-run ignored.
        @(negedge clk); b = cyc;
        ex(b + 2, 4'b0000, 4'b0010);
        ex(b + 5, 4'b0000, 4'b0010);
        ex(b + 6, 4'b0010, 4'b0000);
        ex(b + 7, 4'b0000, 4'b0000);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 4'd3; en[1] = 1'b1; mode[1] = 1'b1;
        wait_to(b + 1); cfg_we = 1'b0; arm[1] = 1'b1;
        wait_to(b + 2); arm[1] = 1'b0;
        wait_to(b + 3); arm[1] = 1'b1;
        wait_to(b + 4); arm[1] = 1'b0;
        wait_to(b + 12); en[1] = 1'b0;
        wait_to(b + 14);

        // Shadow update on ch0: P=2 written at cnt=1, then P=4 written at terminal count.
        @(negedge clk); b = cyc;
        ex(b + 7, 4'b0001, 4'b0001);
        ex(b + 10, 4'b0001, 4'b0001);
        ex(b + 13, 4'b0001, 4'b0001);
        ex(b + 18, 4'b0001, 4'b0001);
        ex(b + 23, 4'b0001, 4'b0001);
        ex(b + 24, 4'b0000, 4'b0000);
        en[0] = 1'b1; mode[0] = 1'b0;
        wait_to(b + 2); cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 4'd2;
        wait_to(b + 3); cfg_we = 1'b0;
        wait_to(b + 12); cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 4'd4;
        wait_to(b + 13); cfg_we = 1'b0;
        wait_to(b + 23); en[0] = 1'b0;
        wait_to(b + 26);

        // en drop on ch2 in its terminal-count cycle, then restart from cnt=0.
        @(negedge clk); b = cyc;
        ex(b + 6, 4'b0000, 4'b0100);
        ex(b + 7, 4'b0000, 4'b0000);
        ex(b + 15, 4'b0100, 4'b0100);
        ex(b + 16, 4'b0000, 4'b0000);
        en[2] = 1'b1; mode[2] = 1'b0;
        wait_to(b + 6); en[2] = 1'b0;
        wait_to(b + 8); en[2] = 1'b1;
        wait_to(b + 15); en[2] = 1'b0;
        wait_to(b + 18);

        // P=0 on ch3: sig every cycle; en drop wins over the terminal count.
        @(negedge clk); b = cyc;
        ex(b + 1, 4'b0000, 4'b1000);
        for (int k = 2; k <= 5; k++) ex(b + k, 4'b1000, 4'b1000);
        ex(b + 6, 4'b0000, 4'b0000);
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 4'd0; en[3] = 1'b1; mode[3] = 1'b0;
        wait_to(b + 1); cfg_we = 1'b0;
        wait_to(b + 5); en[3] = 1'b0;
        wait_to(b + 8);

        // P=15 on ch1 (max value): 16-cycle period, counter reaches 15 without wrapping.
        @(negedge clk); b = cyc;
        ex(b + 17, 4'b0010, 4'b0010);
        ex(b + 33, 4'b0010, 4'b0010);
        ex(b + 34, 4'b0000, 4'b0000);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 4'd15; en[1] = 1'b1; mode[1] = 1'b0;
        wait_to(b + 1); cfg_we = 1'b0;
        wait_to(b + 33); en[1] = 1'b0;
        wait_to(b + 36);

        // All four channels at P=2 pulsing together.
        @(negedge clk); b = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_to(b + k); cfg_we = 1'b1; cfg_ch = 2'(k); cfg_period = 4'd2;
        end
        wait_to(b + 4); cfg_we = 1'b0; b = cyc;
        ex(b + 1, 4'b0000, 4'b1111);
        ex(b + 4, 4'b1111, 4'b1111);
        ex(b + 7, 4'b1111, 4'b1111);
        ex(b + 8, 4'b0000, 4'b0000);
        en = 4'b1111; mode = 4'b0000;
        wait_to(b + 7); en = 4'b0000;
        wait_to(b + 10);

        // Out-of-range channel on the 3-channel instance: cfg_err pulse, periods untouched.
        @(negedge clk); b = cyc;
        ex2(b + 1, 3'b000, 3'b000, 1'b1);
        ex2(b + 2, 3'b000, 3'b000, 1'b0);
        ex2(b + 9, 3'b111, 3'b111, 1'b0);
        ex2(b + 10, 3'b000, 3'b000, 1'b0);
        cfg_we2 = 1'b1; cfg_ch2 = 2'd3; cfg_period2 = 4'd1;
        wait_to(b + 1); cfg_we2 = 1'b0;
        wait_to(b + 2); en2 = 3'b111; mode2 = 3'b000;
        wait_to(b + 9); en2 = 3'b000;
        wait_to(b + 12);

        // Reset mid-count: outputs clear, no pulse, periods return to 5.
        @(negedge clk); b = cyc;
        ex(b + 1, 4'b0000, 4'b1111);
        ex(b + 3, 4'b0000, 4'b0000);
        ex(b + 4, 4'b0000, 4'b0000);
        ex(b + 5, 4'b0000, 4'b1111);
        ex(b + 11, 4'b1111, 4'b1111);
        ex(b + 12, 4'b0000, 4'b0000);
        en = 4'b1111; mode = 4'b0000;
        wait_to(b + 2); #2 rst = 1'b0;
        wait_to(b + 4); rst = 1'b1;
        wait_to(b + 11); en = 4'b0000;
        wait_to(b + 14);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d expectations unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_multi_delay

// File: doc/multi_delay.md
Name: multi_delay

Overview:
- Parametrised successor to the single-channel delay pulse generator: NCH independent channels, each with a runtime-programmable period, periodic or one-shot mode, and per-channel invariant monitors (err/flg).
- Sits beside the formal benchmark suite as a timer source. Properties target liveness (enabled periodic channel eventually pulses) and safety (err never rises).

Parameters:
- NCH, 4, number of channels (1..16).
- CBITS, 19, counter and period width per channel.
- N_DEFAULT, 400000, reset value of every channel period; must fit in CBITS.
- IBITS, $clog2(NCH) min 1, width of the config channel index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; asserted when 0.
- en  input  NCH  per-channel enable; level-sensitive.
- mode  input  NCH  per-channel mode: 0 = periodic, 1 = one-shot; sampled at start.
- arm  input  NCH  one-shot start pulse; ignored in periodic mode.
- cfg_we  input  1  period write strobe.
- cfg_ch  input  IBITS  target channel of the write.
- cfg_period  input  CBITS  new period value P.
- cfg_err  output  1  one-cycle pulse: cfg_we with cfg_ch >= NCH.
- sig  output  NCH  one-cycle terminal-count pulse per channel.
- busy  output  NCH  channel in RUN.
- err  output  NCH  invariant violation: cnt > active period. Must never assert.
- flg  output  NCH  invariant holds: cnt <= active period.
- any_sig  output  1  OR of sig.

Behaviour:
- Reset (rst=0, asynchronous):
  - All cnt=0, state=IDLE, active and shadow periods = N_DEFAULT.
  - sig=0, busy=0, err=0, flg=1, cfg_err=0, any_sig=0.
  - Mid-operation reset aborts counting with no sig pulse.
- Per-channel state machine, IDLE / RUN, with mode latched at entry to RUN.
  - IDLE→RUN:
    - periodic: when en=1 and mode=0.
    - one-shot: when en=1 and mode=1 and arm=1.
    - cnt=0 on entry.
  - RUN, en=1: cnt increments each cycle.
  - Terminal count: when cnt == active period, the next edge sets cnt=0 and pulses sig for exactly one cycle.
    - Periodic: one pulse every P+1 cycles, measured from the first RUN cycle. P=0 gives sig high every cycle.
    - One-shot: after the pulse, return to IDLE and busy drops with the pulse. arm while in RUN is ignored.
  - RUN, en=0: next edge goes to IDLE, cnt=0, no pulse. en=0 wins over a simultaneous terminal count.
- Configuration:
  - cfg_we writes cfg_period into the shadow period of cfg_ch.
  - In IDLE, the shadow is copied to active on the same edge.
  - In RUN, active loads from the shadow only at terminal count, so the current interval is never shortened. A write in the terminal-count cycle is used for the next interval.
  - Out-of-range cfg_ch: no state change; cfg_err pulses 1 cycle later.
- Outputs:
  - All outputs are registered; sig appears the cycle after cnt == P is observed.
  - err and flg are registered comparisons of cnt vs active period; err = ~flg.
  - any_sig is registered with sig.
- Arithmetic:
  - cnt is unsigned CBITS, compared unsigned.
  - cnt never exceeds active period, so it never wraps at 2^CBITS.
  - P = 2^CBITS−1 is legal.

Decomposition:
- Package delay_pkg holds:
  - chan_state_e {IDLE, RUN};
  - mode constants MODE_PERIODIC=0, MODE_ONESHOT=1;
  - N_DEFAULT_G=400000.
- Sub-module delay_chan: one channel (counter, FSM, shadow/active period, sig/err/flg), instantiated NCH times by generate.
- The top holds only config decode, cfg_err and any_sig.

Test Plan:
- Bench configuration: NCH=4, CBITS=4, N_DEFAULT=5.
- Periodic: release rst, en[0]=1, mode[0]=0 → sig[0] pulses every 6 cycles, err stays 0, flg stays 1.
- One-shot: cfg P=3 on ch1, mode=1, pulse arm[1] → busy[1] for 4 cycles, a single sig[1], then IDLE. A second arm mid-run produces no extra pulse.
- Shadow update: ch0 running at P=5, write P=2 at cnt=1 → the current interval stays 6 cycles, later intervals are 3 cycles. A write at the terminal-count cycle takes effect in the next interval.
- en drop: deassert en[2] in the terminal-count cycle → no sig[2], cnt=0, busy=0 next cycle.
- Boundaries:
  - P=0 periodic → sig high every cycle.
  - P=15 → period of 16 cycles, no wrap, err=0.
  - Four channels pulsing together → any_sig=1.
- Errors/reset:
  - cfg_ch=3 with NCH=3 → cfg_err one pulse, no period change.
  - rst low mid-count → outputs at reset values immediately; periods back to 5.
